// File: rtl/snd_mixer_mc_pkg.sv
// Shared types for the multi-channel sound mixer: pan routing codes and mixer FSM states.
package snd_mixer_mc_pkg;

    typedef enum logic [1:0] {
        PAN_MUTE = 2'b00,
        PAN_L    = 2'b01,
        PAN_R    = 2'b10,
        PAN_LR   = 2'b11
    } pan_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        LATCH = 2'd2
    } mix_state_t;

endpackage

// File: rtl/snd_mixer_mc_sd_dac1.sv
// First-order sigma-delta modulator: the carry out of sd + pcm is the output bitstream.
module sd_dac1 #(
    parameter int W = 10
) (
    input  logic         clk28,
    input  logic         rst_n,
    input  logic [W-1:0] pcm,
    output logic         dac
);

    logic [W-1:0] sd;
    logic [W:0]   sum;

    assign sum = {1'b0, sd} + {1'b0, pcm};

    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            sd  <= '0;
            dac <= 1'b0;
        end else begin
            sd  <= sum[W-1:0];
            dac <= sum[W];
        end
    end

endmodule

// File: rtl/snd_mixer_mc.sv
// Multi-channel volume/pan mixer: one channel accumulated per clk28, two sigma-delta outputs.
// Define MIXER_SAT_EN for output gain (GAIN_SHIFT) with saturation and clip flags.
module snd_mixer_mc
    import snd_mixer_mc_pkg::*;
#(
    parameter int CHANNELS   = 6,
    parameter int WIDTH      = 8,
    parameter int SAMPLE_DIV = 64,
    parameter int GAIN_SHIFT = 1
) (
    input  logic                      clk28,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] ch_data,
    input  logic [CHANNELS*3-1:0]     ch_vol,
    input  logic [CHANNELS*2-1:0]     ch_pan,
    output logic                      dac_l,
    output logic                      dac_r,
    output logic                      sample_stb,
    output logic                      clip_l,
    output logic                      clip_r
);

    // state | meaning
    // IDLE  | wait for pcnt==0, then clear accumulators and start at channel 0
    // ACC   | add channel ci's scaled term to the enabled sides, advance ci
    // LATCH | transfer accumulators to pcm (with optional gain/saturation)

    localparam int SUM_W = WIDTH + $clog2(CHANNELS);
    localparam int CI_W  = $clog2(CHANNELS);
    localparam int PC_W  = $clog2(SAMPLE_DIV);
    localparam logic [CI_W-1:0] CI_LAST = CI_W'(CHANNELS - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(SAMPLE_DIV - 1);

    mix_state_t state, state_nxt;

    logic [PC_W-1:0]  pcnt;
    logic [CI_W-1:0]  ci;
    logic [SUM_W-1:0] acc_l, acc_r;
    logic [SUM_W-1:0] pcm_l, pcm_r;
    logic [SUM_W-1:0] sat_l, sat_r;
    logic             over_l, over_r;

    logic [WIDTH-1:0] cur_data;
    logic [2:0]       cur_vol;
    pan_t             cur_pan;
    logic [3:0]       gain;
    logic [WIDTH+2:0] prod;
    logic [SUM_W-1:0] term;
    logic             add_l, add_r;
    logic             unused_prod_lsb;
    logic             unused_gain;

    assign cur_data = ch_data[ci*WIDTH +: WIDTH];
    assign cur_vol  = ch_vol[ci*3 +: 3];
    assign cur_pan  = pan_t'(ch_pan[ci*2 +: 2]);
    assign gain     = {1'b0, cur_vol} + 4'd1;

    // data * (vol+1) built from shifted copies of data, one per set bit of the gain
    always_comb begin
        prod = '0;
        for (int b = 0; b < 4; b++) begin
            if (gain[b]) begin
                prod = prod + ({3'b000, cur_data} << b);
            end
        end
    end

    assign term            = SUM_W'(prod[WIDTH+2:3]);
    assign unused_prod_lsb = ^prod[2:0];

`ifdef MIXER_SAT_EN
    localparam int SH_W = SUM_W + GAIN_SHIFT;
    logic [SH_W-1:0] sh_l, sh_r;

    assign sh_l        = SH_W'(acc_l) << GAIN_SHIFT;
    assign sh_r        = SH_W'(acc_r) << GAIN_SHIFT;
    assign over_l      = (sh_l >> SUM_W) != '0;
    assign over_r      = (sh_r >> SUM_W) != '0;
    assign sat_l       = over_l ? '1 : sh_l[SUM_W-1:0];
    assign sat_r       = over_r ? '1 : sh_r[SUM_W-1:0];
    assign unused_gain = 1'b0;
`else
    assign over_l      = 1'b0;
    assign over_r      = 1'b0;
    assign sat_l       = acc_l;
    assign sat_r       = acc_r;
    assign unused_gain = (GAIN_SHIFT != 0);
`endif

    always_comb begin
        state_nxt = state;
        add_l     = 1'b0;
        add_r     = 1'b0;
        case (state)
            IDLE: begin
                if (pcnt == '0) state_nxt = ACC;
            end
            ACC: begin
                add_l = (cur_pan == PAN_L) || (cur_pan == PAN_LR);
                add_r = (cur_pan == PAN_R) || (cur_pan == PAN_LR);
                if (ci == CI_LAST) state_nxt = LATCH;
            end
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk28) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            pcnt       <= '0;
            ci         <= '0;
            acc_l      <= '0;
            acc_r      <= '0;
            pcm_l      <= '0;
            pcm_r      <= '0;
            clip_l     <= 1'b0;
            clip_r     <= 1'b0;
            sample_stb <= 1'b0;
        end else begin
            pcnt       <= (pcnt == PC_LAST) ? '0 : pcnt + 1'b1;
            sample_stb <= (state == LATCH);
            case (state)
                IDLE: begin
                    if (pcnt == '0) begin
                        acc_l <= '0;
                        acc_r <= '0;
                        ci    <= '0;
                    end
                end
                ACC: begin
                    if (add_l) acc_l <= acc_l + term;
                    if (add_r) acc_r <= acc_r + term;
                    ci <= (ci == CI_LAST) ? '0 : ci + 1'b1;
                end
                LATCH: begin
                    pcm_l  <= sat_l;
                    pcm_r  <= sat_r;
                    clip_l <= over_l;
                    clip_r <= over_r;
                end
                default: ;
            endcase
        end
    end

    sd_dac1 #(.W(SUM_W)) u_dac_l (
        .clk28 (clk28),
        .rst_n (rst_n),
        .pcm   (pcm_l),
        .dac   (dac_l)
    );

    sd_dac1 #(.W(SUM_W)) u_dac_r (
        .clk28 (clk28),
        .rst_n (rst_n),
        .pcm   (pcm_r),
        .dac   (dac_r)
    );

endmodule

// File: tb/tb_snd_mixer_mc.sv
// Directed bench for snd_mixer_mc (4 channels, 8-bit, 32-cycle period) with a pcm scoreboard.
module tb_snd_mixer_mc;

    localparam int CH  = 4;
    localparam int W   = 8;
    localparam int DIV = 32;
    localparam int GS  = 1;
    localparam int SW  = 10;

    logic            clk28 = 1'b0;
    logic            rst_n;
    logic [CH*W-1:0] ch_data;
    logic [CH*3-1:0] ch_vol;
    logic [CH*2-1:0] ch_pan;
    logic            dac_l, dac_r, sample_stb, clip_l, clip_r;

    int d[CH];
    int v[CH];
    int p[CH];

    typedef struct {
        int l;
        int r;
        int cl;
        int cr;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    always #5 clk28 = ~clk28;
    always @(posedge clk28) cyc++;

    snd_mixer_mc #(
        .CHANNELS   (CH),
        .WIDTH      (W),
        .SAMPLE_DIV (DIV),
        .GAIN_SHIFT (GS)
    ) dut (
        .clk28      (clk28),
        .rst_n      (rst_n),
        .ch_data    (ch_data),
        .ch_vol     (ch_vol),
        .ch_pan     (ch_pan),
        .dac_l      (dac_l),
        .dac_r      (dac_r),
        .sample_stb (sample_stb),
        .clip_l     (clip_l),
        .clip_r     (clip_r)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_chans();
        for (int i = 0; i < CH; i++) begin
            d[i] = 0;
            v[i] = 0;
            p[i] = 0;
        end
    endtask

    task automatic apply();
        for (int i = 0; i < CH; i++) begin
            ch_data[i*W +: W] = d[i][W-1:0];
            ch_vol[i*3 +: 3]  = v[i][2:0];
            ch_pan[i*2 +: 2]  = p[i][1:0];
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.l  = 0;
        e.r  = 0;
        e.cl = 0;
        e.cr = 0;
        for (int i = 0; i < CH; i++) begin
            int t;
            t = (d[i] * (v[i] + 1)) / 8;
            if (p[i] % 2 == 1) e.l += t;
            if (p[i] >= 2)     e.r += t;
        end
`ifdef MIXER_SAT_EN
        e.l = e.l * (1 << GS);
        e.r = e.r * (1 << GS);
        if (e.l > (1 << SW) - 1) begin e.l = (1 << SW) - 1; e.cl = 1; end
        if (e.r > (1 << SW) - 1) begin e.r = (1 << SW) - 1; e.cr = 1; end
`endif
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_pcm_l"}, 32'(dut.pcm_l), e.l);
            check({tag, "_pcm_r"}, 32'(dut.pcm_r), e.r);
            check({tag, "_clip_l"}, 32'(clip_l), e.cl);
            check({tag, "_clip_r"}, 32'(clip_r), e.cr);
        end
    endtask

    // Returns the number of clk28 edges until sample_stb is seen (bounded).
    task automatic wait_stb(input string tag, output int n);
        int c0;
        c0 = cyc;
        n  = 0;
        do begin
            @(negedge clk28);
            n++;
        end while (!sample_stb && n < 200);
        if (!sample_stb) check({tag, "_stb_timeout"}, 32'(sample_stb), 1);
        n = cyc - c0;
    endtask

    task automatic count_ones(input int len, output int ol, output int orr);
        ol  = 0;
        orr = 0;
        repeat (len) begin
            @(negedge clk28);
            ol  += int'(dac_l);
            orr += int'(dac_r);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dac_l"}, 32'(dac_l), 0);
        check({tag, "_dac_r"}, 32'(dac_r), 0);
        check({tag, "_stb"}, 32'(sample_stb), 0);
        check({tag, "_clip_l"}, 32'(clip_l), 0);
        check({tag, "_clip_r"}, 32'(clip_r), 0);
        check({tag, "_pcm_l"}, 32'(dut.pcm_l), 0);
        check({tag, "_pcm_r"}, 32'(dut.pcm_r), 0);
    endtask

    initial begin
        int n, ol, orr, c0;
        exp_t dummy;

        // Reset with ch0 full scale, unity gain, both sides.
        rst_n = 1'b0;
        clear_chans();
        d[0] = 255; v[0] = 7; p[0] = 3;
        apply();
        repeat (4) @(negedge clk28);
        check_reset_outputs("reset");
        push_exp();
        rst_n = 1'b1;
        wait_stb("first", n);
        check("first_stb_delay", n, CH + 2);
        pop_check("A");
        @(negedge clk28);
        check("stb_width", 32'(sample_stb), 0);
        for (int k = 0; k < 3; k++) begin
            c0 = cyc;
            wait_stb("period", n);
            check("stb_period", 32'(cyc - c0 + 1), DIV);
            @(negedge clk28);
        end
        count_ones(1 << SW, ol, orr);
        check("A_dac_l_density", ol, 255);
        check("A_dac_r_density", orr, 255);

        // ch1 at half volume, left only.
        wait_stb("B_sync", n);
        clear_chans();
        d[1] = 200; v[1] = 3; p[1] = 1;
        apply();
        push_exp();
        wait_stb("B", n);
        pop_check("B");
        @(negedge clk28);
        count_ones(1 << SW, ol, orr);
        check("B_dac_l_density", ol, 100);
        check("B_dac_r_zero", orr, 0);

        // All channels full scale: saturation / headroom corner.
        wait_stb("C_sync", n);
        for (int i = 0; i < CH; i++) begin
            d[i] = 255; v[i] = 7; p[i] = 3;
        end
        apply();
        push_exp();
        wait_stb("C", n);
        pop_check("C");

        // Mixed volumes and routings, including a muted channel.
        wait_stb("D_sync", n);
        clear_chans();
        d[0] = 100; v[0] = 0; p[0] = 1;
        d[1] = 37;  v[1] = 5; p[1] = 2;
        d[2] = 255; v[2] = 2; p[2] = 0;
        d[3] = 10;  v[3] = 7; p[3] = 3;
        apply();
        push_exp();
        wait_stb("D", n);
        pop_check("D");

        // Mid-period change: ch3 rises during ch2's slot, ch0 drops after its own slot.
        wait_stb("F_sync", n);
        clear_chans();
        d[0] = 50; v[0] = 7; p[0] = 3;
        v[3] = 7;  p[3] = 2;
        apply();
        repeat (29) @(negedge clk28);
        d[3] = 80;
        push_exp();
        d[0] = 0;
        apply();
        wait_stb("F", n);
        pop_check("F");

        // Reset in the middle of accumulation.
        wait_stb("G_sync", n);
        clear_chans();
        d[0] = 255; v[0] = 7; p[0] = 3;
        d[1] = 255; v[1] = 7; p[1] = 3;
        apply();
        repeat (29) @(negedge clk28);
        check("G_ci_at_reset", 32'(dut.ci), 2);
        rst_n = 1'b0;
        clear_chans();
        d[2] = 160; v[2] = 7; p[2] = 1;
        apply();
        repeat (3) @(negedge clk28);
        check_reset_outputs("G_reset");
        check("G_acc_l_cleared", 32'(dut.acc_l), 0);
        push_exp();
        rst_n = 1'b1;
        wait_stb("G", n);
        check("G_stb_delay", n, CH + 2);
        pop_check("G");

        dummy.l = sb.size();
        check("sb_drained", 32'(dummy.l), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
